inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-002 Parameter MAX_WORDS, default 'h20000: largest legal word count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetN  input  1  synchronous, active-low reset.
REQ-005 inByte  input  8  incoming stream byte.
REQ-006 inValid  input  1  inByte valid.
REQ-007 inReady  output  1  loader accepts a byte; transfer occurs when inValid and inReady are both high at the edge.
REQ-008 clear  input  1  one-cycle request to leave DONE or ERROR and start a new load.
REQ-009 memWe  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 memAddr  output  32  word-aligned byte address of the write.
REQ-011 memData  output  32  instruction word to write.
REQ-012 busy  output  1  high in LEN, DATA and CHECK.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted.
REQ-015 wordCount  output  32  words written in the current load.

Function
REQ-016 Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, least significant byte first.
REQ-017 State machine states: LEN, DATA, CHECK, DONE, ERROR.
- LEN: collects 4 count bytes.
- DATA: collects words.
- CHECK: present only with the checksum feature.
- DONE and ERROR: sticky.
REQ-018 inReady is high in LEN, DATA and CHECK, and low in DONE and ERROR; it never depends combinationally on inValid.
REQ-019 Transitions out of LEN on acceptance of the 4th count byte:
- N > MAX_WORDS: go to ERROR; no writes.
- N == 0: go to CHECK, or to DONE without the checksum feature.
- Otherwise: go to DATA.
REQ-020 When the 4th byte of word k (k from 0) is accepted, memWe is high in the next cycle, for exactly one cycle, with memAddr = BASE_ADDR + 4*k and memData = assembled word.
REQ-021 The loader accepts bytes back-to-back at one byte per cycle; a write strobe never stalls the stream.
REQ-022 inValid low holds all byte, word and count state unchanged.
REQ-023 On acceptance of the final byte of word N-1, the state goes to CHECK, or to DONE without the checksum feature. done and the final memWe are high in the same cycle.
REQ-024 wordCount increments in each memWe cycle, wrapping modulo 2^32, and resets to 0 on leaving DONE or ERROR.
REQ-025 clear is honoured only in DONE or ERROR: the next state is LEN, and done, error and all byte, word and count state are zeroed. clear in any other state is ignored.
REQ-026 done and error are never high together; busy is exactly the logical NOT of (done OR error).
REQ-027 memAddr arithmetic is 32-bit and wraps silently; BASE_ADDR must be word-aligned.

Reset
REQ-028 When resetN is low at an edge:
- State goes to LEN.
- inReady=1, busy=1.
- memWe=0, memAddr=0, memData=0.
- done=0, error=0, wordCount=0.
- Byte index and checksum are zeroed.
REQ-029 Reset mid-load discards any partial word and writes nothing further; an already-issued memWe is not retracted.

Configuration
REQ-030 Macro INST_LOADER_CHECKSUM_EN, when defined:
- After the last data word (or after the count when N == 0), the loader accepts one checksum byte in CHECK.
- The checksum is the XOR of all 4*N data bytes; count bytes are excluded.
- Match goes to DONE; mismatch goes to ERROR.
- Words already written stay written.
REQ-031 Without INST_LOADER_CHECKSUM_EN, CHECK and the checksum register do not exist and the loader consumes no trailing byte.

Structure
REQ-032 The word-width macro `WORD` comes from the shared ISA.v definitions; the state encodings and the 4-bytes-per-word constant are placed in that shared header.
REQ-033 One sub-module, word_assembler, holds the byte-to-word shift register and 2-bit byte index; inst_loader holds the state machine, counters and write port.

Verification
REQ-034 Stream 01 00 00 00, 78 56 34 12 -> exactly one memWe with memAddr=0x00000000 and memData=0x12345678; done=1 in that same cycle; wordCount=1.
REQ-035 BASE_ADDR=0x400, N=3, words 0xA, 0xB, 0xC with inValid toggling every other cycle -> writes at 0x400, 0x404, 0x408 with data 0xA, 0xB, 0xC in that order; no extra memWe.
REQ-036 Count bytes 00 00 03 00 (0x30000 > MAX_WORDS) -> error=1 and inReady=0 after the 4th byte; zero writes; clear then returns to LEN with error=0.
REQ-037 N=0 -> done after 4 bytes with no memWe; with INST_LOADER_CHECKSUM_EN, checksum byte 00 is required before done.
REQ-038 With INST_LOADER_CHECKSUM_EN, one word 0x11223344 followed by checksum 0x44 -> done; the same word followed by checksum 0x45 -> error, while the memWe for that word still occurred.
REQ-039 resetN low for one cycle after 6 of 8 data bytes -> no further memWe, state LEN, wordCount=0; a fresh 1-word stream then loads correctly at BASE_ADDR.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: word geometry and FSM state encoding.
// Build option: INST_LOADER_CHECKSUM_EN adds the CHECK state (trailing XOR checksum byte).
package inst_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;
`endif

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word assembler: collects little-endian bytes into a word.
// word_c is the complete word when last_c is high and the current byte is accepted.
module word_assembler
    import inst_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  clr,
    input  logic                  en,
    input  logic [BYTE_W-1:0]     in_byte,
    output logic [WORD_W-1:0]     word_c,
    output logic                  last_c
);

    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [SR_W-1:0]       sr_q, sr_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    // Shift each accepted byte in at the top so the oldest byte ends up in the low lane.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (clr) begin
            sr_d  = '0;
            idx_d = '0;
        end else if (en) begin
            sr_d  = {in_byte, sr_q[SR_W-1:BYTE_W]};
            idx_d = idx_q + BYTE_IDX_W'(1);
        end
    end

    // Shift register and byte index.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign word_c = {in_byte, sr_q};
    assign last_c = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: parses a length-prefixed little-endian byte stream and
// writes the words to instruction memory starting at BASE_ADDR.
// Build option: INST_LOADER_CHECKSUM_EN requires a trailing XOR checksum byte.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [WORD_W-1:0] MAX_WORDS = 32'h0002_0000
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [BYTE_W-1:0]   inByte,
    input  logic                inValid,
    output logic                inReady,
    input  logic                clear,
    output logic                memWe,
    output logic [WORD_W-1:0]   memAddr,
    output logic [WORD_W-1:0]   memData,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WORD_W-1:0]   wordCount
);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_e ST_TAIL = ST_CHECK;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [WORD_W-1:0]   word_idx_q, word_idx_d;
    logic [WORD_W-1:0]   word_count_q, word_count_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_we_q, mem_we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   chk_q, chk_d;
`endif

    logic                accept_c;
    logic                asm_en_c;
    logic                asm_clr_c;
    logic [WORD_W-1:0]   asm_word_c;
    logic                asm_last_c;

    assign accept_c = inValid & ready_q;

    word_assembler u_word_assembler (
        .clk     (clk),
        .resetN  (resetN),
        .clr     (asm_clr_c),
        .en      (asm_en_c),
        .in_byte (inByte),
        .word_c  (asm_word_c),
        .last_c  (asm_last_c)
    );

    // Next-state, write port and status decode.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        asm_en_c     = 1'b0;
        asm_clr_c    = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif

        unique case (state_q)
            ST_LEN: begin
                asm_en_c = accept_c;
                if (accept_c && asm_last_c) begin
                    len_d      = asm_word_c;
                    word_idx_d = '0;
                    if (asm_word_c > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (asm_word_c == '0) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                asm_en_c = accept_c;
                if (accept_c) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ inByte;
`endif
                    if (asm_last_c) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR + (word_idx_q << BYTE_IDX_W);
                        mem_data_d   = asm_word_c;
                        word_count_d = word_count_q + WORD_W'(1);
                        word_idx_d   = word_idx_q + WORD_W'(1);
                        if (word_idx_q == len_q - WORD_W'(1)) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
            end

`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_c) begin
                    state_d = (inByte == chk_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif

            ST_DONE, ST_ERROR: begin
                if (clear) begin
                    state_d      = ST_LEN;
                    len_d        = '0;
                    word_idx_d   = '0;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                    mem_data_d   = '0;
                    asm_clr_c    = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    chk_d        = '0;
`endif
                end
            end

            default: begin
                state_d = ST_LEN;
            end
        endcase

        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
        ready_d = !(done_d || error_d);
        busy_d  = ready_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= ST_LEN;
            len_q        <= '0;
            word_idx_q   <= '0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running XOR of data bytes.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    assign inReady   = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign memWe     = mem_we_q;
    assign memAddr   = mem_addr_q;
    assign memData   = mem_data_q;
    assign wordCount = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector table, hand sequences and random
// streams compared against a stream-level reference model.
module tb_inst_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_0400;
    localparam logic [31:0] TB_MAX  = 32'd8;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        resetN;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        clear;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] wordCount;

    inst_loader #(.BASE_ADDR(TB_BASE), .MAX_WORDS(TB_MAX)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .inByte    (inByte),
        .inValid   (inValid),
        .inReady   (inReady),
        .clear     (clear),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memData   (memData),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .wordCount (wordCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          dn;
        logic [31:0] wc;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  stim_q[$];
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_wc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Capture every write strobe.
    always @(negedge clk) begin
        wr_t r;
        if (memWe === 1'b1) begin
            r.addr = memAddr;
            r.data = memData;
            r.dn   = done;
            r.wc   = wordCount;
            wr_q.push_back(r);
        end
    end

    // Status invariants hold in every cycle.
    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            chk("inv_excl", 32'(done & error), 32'd0);
            chk("inv_busy", 32'(busy), 32'(!(done | error)));
            chk("inv_ready", 32'(inReady), 32'(busy));
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic clr);
        inValid = v;
        inByte  = b;
        clear   = clr;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        resetN = 1'b1;
    endtask

    task automatic do_clear(input string tag);
        cyc(1'b0, 8'h00, 1'b1);
        chk({tag, ":clr_done"}, 32'(done), 32'd0);
        chk({tag, ":clr_err"}, 32'(error), 32'd0);
        chk({tag, ":clr_rdy"}, 32'(inReady), 32'd1);
        chk({tag, ":clr_wc"}, wordCount, 32'd0);
    endtask

    function automatic void push_count(input logic [31:0] n);
        for (int i = 0; i < 4; i++) stim_q.push_back(8'(n >> (8 * i)));
    endfunction

    function automatic void push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim_q.push_back(8'(w >> (8 * i)));
    endfunction

    function automatic logic [7:0] xor_data();
        logic [7:0] x = 8'h00;
        for (int i = 4; i < stim_q.size(); i++) x ^= stim_q[i];
        return x;
    endfunction

    // Reference model: interpret the whole stream from the format rules.
    function automatic void run_model();
        logic [31:0] n;
        logic [7:0]  x;
        wr_t         r;
        int          b;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_wc   = 32'd0;
        x        = 8'h00;
        if (stim_q.size() < 4) return;
        n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        if (n > TB_MAX) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            b = 4 + 4 * k;
            if (stim_q.size() < b + 4) return;
            r.addr = TB_BASE + 32'(4 * k);
            r.data = {stim_q[b+3], stim_q[b+2], stim_q[b+1], stim_q[b]};
            r.dn   = !CHK_EN && (k == int'(n) - 1);
            r.wc   = 32'(k + 1);
            x      = x ^ stim_q[b] ^ stim_q[b+1] ^ stim_q[b+2] ^ stim_q[b+3];
            exp_q.push_back(r);
            exp_wc = 32'(k + 1);
        end
        if (CHK_EN) begin
            b = 4 + 4 * int'(n);
            if (stim_q.size() > b) begin
                if (stim_q[b] == x) exp_done = 1'b1;
                else exp_err = 1'b1;
            end
        end else begin
            exp_done = 1'b1;
        end
    endfunction

    task automatic send_stream(input int gap_mode);
        foreach (stim_q[i]) begin
            if (gap_mode == 1 && i > 0) cyc(1'b0, 8'($urandom), 1'b0);
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) cyc(1'b0, 8'($urandom), 1'b0);
            cyc(1'b1, stim_q[i], 1'b0);
        end
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_result(input string tag);
        chk({tag, ":nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s:addr%0d", tag, i), wr_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s:data%0d", tag, i), wr_q[i].data, exp_q[i].data);
            chk($sformatf("%s:wdone%0d", tag, i), 32'(wr_q[i].dn), 32'(exp_q[i].dn));
            chk($sformatf("%s:wwc%0d", tag, i), wr_q[i].wc, exp_q[i].wc);
        end
        chk({tag, ":done"}, 32'(done), 32'(exp_done));
        chk({tag, ":error"}, 32'(error), 32'(exp_err));
        chk({tag, ":wc"}, wordCount, exp_wc);
        chk({tag, ":ready"}, 32'(inReady), 32'(!(exp_done | exp_err)));
    endtask

    vec_t tbl[8];

    initial begin
        resetN  = 1'b0;
        inValid = 1'b0;
        inByte  = 8'h00;
        clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;

        // Reset values
        chk("rst_ready", 32'(inReady), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we", 32'(memWe), 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_data", memData, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_wc", wordCount, 32'd0);

        // Vector table: count, first word, gap mode, expected done/error/writes
        tbl[0] = '{32'd1,          32'h1234_5678, 0, 1'b1, 1'b0, 1};
        tbl[1] = '{32'd0,          32'h0000_0000, 0, 1'b1, 1'b0, 0};
        tbl[2] = '{32'd8,          32'hDEAD_BEEF, 0, 1'b1, 1'b0, 8};
        tbl[3] = '{32'd9,          32'h5555_AAAA, 0, 1'b0, 1'b1, 0};
        tbl[4] = '{32'h0003_0000,  32'h0000_0000, 0, 1'b0, 1'b1, 0};
        tbl[5] = '{32'd3,          32'h0000_000A, 1, 1'b1, 1'b0, 3};
        tbl[6] = '{32'd2,          32'hFFFF_FFFF, 2, 1'b1, 1'b0, 2};
        tbl[7] = '{32'hFFFF_FFFF,  32'h0000_0000, 1, 1'b0, 1'b1, 0};

        for (int t = 0; t < 8; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            stim_q.delete();
            wr_q.delete();
            push_count(tbl[t].n);
            if (tbl[t].n <= TB_MAX + 32'd1)
                for (int k = 0; k < int'(tbl[t].n); k++) push_word(tbl[t].w0 + 32'(k));
            if (CHK_EN && !tbl[t].exp_err) stim_q.push_back(xor_data());
            run_model();
            send_stream(tbl[t].gap);
            check_result(tag);
            chk({tag, ":tbl_nwr"}, 32'(wr_q.size()), 32'(tbl[t].exp_writes));
            chk({tag, ":tbl_done"}, 32'(done), 32'(tbl[t].exp_done));
            chk({tag, ":tbl_err"}, 32'(error), 32'(tbl[t].exp_err));
            if (wr_q.size() > 0) begin
                chk({tag, ":tbl_addr0"}, wr_q[0].addr, TB_BASE);
                chk({tag, ":tbl_data0"}, wr_q[0].data, tbl[t].w0);
            end
            do_clear(tag);
        end

        // Oversized count: error immediately, bytes ignored, clear recovers
        stim_q.delete();
        wr_q.delete();
        push_count(32'h0003_0000);
        foreach (stim_q[i]) cyc(1'b1, stim_q[i], 1'b0);
        chk("ovf:error", 32'(error), 32'd1);
        chk("ovf:ready", 32'(inReady), 32'd0);
        repeat (8) cyc(1'b1, 8'($urandom), 1'b0);
        chk("ovf:sticky", 32'(error), 32'd1);
        chk("ovf:nwr", 32'(wr_q.size()), 32'd0);
        do_clear("ovf");
        chk("ovf:busy", 32'(busy), 32'd1);

        // clear while loading is ignored
        stim_q.delete();
        wr_q.delete();
        push_count(32'd1);
        push_word(32'h0BAD_F00D);
        if (CHK_EN) stim_q.push_back(xor_data());
        run_model();
        for (int i = 0; i < 6; i++) cyc(1'b1, stim_q[i], 1'b0);
        cyc(1'b0, 8'hFF, 1'b1);
        chk("clr_ign:busy", 32'(busy), 32'd1);
        for (int i = 6; i < stim_q.size(); i++) cyc(1'b1, stim_q[i], 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        check_result("clr_ign");
        do_clear("clr_ign");

        // Reset after 6 of 8 data bytes
        stim_q.delete();
        wr_q.delete();
        push_count(32'd2);
        push_word(32'h0102_0304);
        push_word(32'h0506_0708);
        for (int i = 0; i < 10; i++) cyc(1'b1, stim_q[i], 1'b0);
        do_reset();
        chk("mrst:ready", 32'(inReady), 32'd1);
        chk("mrst:busy", 32'(busy), 32'd1);
        chk("mrst:wc", wordCount, 32'd0);
        chk("mrst:we", 32'(memWe), 32'd0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        chk("mrst:nwr", 32'(wr_q.size()), 32'd1);
        stim_q.delete();
        wr_q.delete();
        push_count(32'd1);
        push_word(32'hCAFE_F00D);
        if (CHK_EN) stim_q.push_back(xor_data());
        run_model();
        send_stream(0);
        check_result("mrst_fresh");
        if (wr_q.size() > 0) chk("mrst_fresh:addr", wr_q[0].addr, TB_BASE);
        do_clear("mrst_fresh");

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on word 0x11223344
        for (int c = 0; c < 2; c++) begin
            string tag;
            tag = $sformatf("cks%0d", c);
            stim_q.delete();
            wr_q.delete();
            push_count(32'd1);
            push_word(32'h1122_3344);
            stim_q.push_back(c == 0 ? 8'h44 : 8'h45);
            run_model();
            send_stream(0);
            check_result(tag);
            chk({tag, ":nwr1"}, 32'(wr_q.size()), 32'd1);
            chk({tag, ":done_k"}, 32'(done), 32'(c == 0));
            chk({tag, ":err_k"}, 32'(error), 32'(c == 1));
            do_clear(tag);
        end
`endif

        // Random streams against the model
        for (int it = 0; it < 25; it++) begin
            string tag;
            int    n;
            tag = $sformatf("rnd%0d", it);
            n   = $urandom_range(0, int'(TB_MAX) + 2);
            stim_q.delete();
            wr_q.delete();
            push_count(32'(n));
            for (int k = 0; k < n; k++) push_word($urandom);
            if (CHK_EN) stim_q.push_back(($urandom_range(0, 3) == 0) ? (xor_data() ^ 8'(1 + $urandom_range(0, 254))) : xor_data());
            run_model();
            send_stream($urandom_range(0, 2));
            check_result(tag);
            do_clear(tag);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
